gearbox_block_sync: RTL and testbench

- 64b/66b block-alignment controller that sequences the slip input of `gearbox32to66`.
- Checks the 2-bit sync header of each 66-bit word from the gearbox.
- Pulses `slip_o` until header alignment is found, then declares lock.
- While locked, monitors header errors and drops lock / resumes hunting when the error threshold is reached in a monitoring window.

---
 rtl/gearbox_block_sync.sv | 149 ++++++++++++++
 tb/tb_gearbox_block_sync.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gearbox_block_sync.sv
// 64b/66b block-alignment controller: hunts for sync-header alignment by pulsing slip_o, then monitors lock.
// Define BLOCK_SYNC_STATS_EN to add saturating slip/unlock statistics outputs.
module gearbox_block_sync #(
    parameter int LOCK_CNT   = 64,
    parameter int WINDOW     = 64,
    parameter int UNLOCK_BAD = 16,
    parameter int SLIP_WAIT  = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [65:0] data66_i,
    input  logic        data66_valid_i,
    output logic        slip_o,
    output logic        locked_o
`ifdef BLOCK_SYNC_STATS_EN
    ,
    output logic [15:0] slip_cnt_o,
    output logic [15:0] unlock_cnt_o
`endif
);

    localparam int MAX_AB = (LOCK_CNT > WINDOW) ? LOCK_CNT : WINDOW;
    localparam int MAX_CD = (UNLOCK_BAD > SLIP_WAIT) ? UNLOCK_BAD : SLIP_WAIT;
    localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW     = $clog2(MAX_P + 1);

    if (LOCK_CNT < 1 || UNLOCK_BAD < 1 || WINDOW < UNLOCK_BAD || SLIP_WAIT < 1) begin : g_param_check
        $error("gearbox_block_sync: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        ST_HUNT      = 2'd0,
        ST_SLIP_WAIT = 2'd1,
        ST_LOCKED    = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] good_q, good_d;
    logic [CW-1:0] wait_q, wait_d;
    logic [CW-1:0] win_q, win_d;
    logic [CW-1:0] bad_q, bad_d;
    logic          slip_d;
    logic          hdr_ok;

    // Only the sync header matters here; the payload is folded away on purpose.
    logic unused_payload;
    assign unused_payload = ^data66_i[63:0];

    assign hdr_ok = data66_i[65] ^ data66_i[64];

    always_comb begin
        // NOTE: every combinational output is defaulted first so no path can infer a latch.
        state_d = state_q;
        good_d  = good_q;
        wait_d  = wait_q;
        win_d   = win_q;
        bad_d   = bad_q;
        slip_d  = 1'b0;
        if (data66_valid_i) begin
            case (state_q)
                ST_HUNT: begin
                    if (!hdr_ok) begin
                        state_d = ST_SLIP_WAIT;
                        good_d  = '0;
                        wait_d  = CW'(SLIP_WAIT);
                        slip_d  = 1'b1;
                    end else if (good_q == CW'(LOCK_CNT - 1)) begin
                        state_d = ST_LOCKED;
                        good_d  = '0;
                    end else begin
                        good_d = good_q + CW'(1);
                    end
                end
                ST_SLIP_WAIT: begin
                    // Headers are meaningless while the gearbox realigns; just count words.
                    if (wait_q == CW'(1)) begin
                        state_d = ST_HUNT;
                        wait_d  = '0;
                        good_d  = '0;
                    end else begin
                        wait_d = wait_q - CW'(1);
                    end
                end
                ST_LOCKED: begin
                    if (!hdr_ok && bad_q == CW'(UNLOCK_BAD - 1)) begin
                        state_d = ST_SLIP_WAIT;
                        wait_d  = CW'(SLIP_WAIT);
                        win_d   = '0;
                        bad_d   = '0;
                        good_d  = '0;
                        slip_d  = 1'b1;
                    end else if (win_q == CW'(WINDOW - 1)) begin
                        win_d = '0;
                        bad_d = '0;
                    end else begin
                        win_d = win_q + CW'(1);
                        if (!hdr_ok) begin
                            bad_d = bad_q + CW'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst_i) begin
            state_q  <= ST_HUNT;
            good_q   <= '0;
            wait_q   <= '0;
            win_q    <= '0;
            bad_q    <= '0;
            slip_o   <= 1'b0;
            locked_o <= 1'b0;
        end else begin
            state_q  <= state_d;
            good_q   <= good_d;
            wait_q   <= wait_d;
            win_q    <= win_d;
            bad_q    <= bad_d;
            slip_o   <= slip_d;
            locked_o <= (state_d == ST_LOCKED);
        end
    end

`ifdef BLOCK_SYNC_STATS_EN
    logic unlock_ev;
    assign unlock_ev = (state_q == ST_LOCKED) && (state_d == ST_SLIP_WAIT);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slip_cnt_o   <= '0;
            unlock_cnt_o <= '0;
        end else begin
            if (slip_d && slip_cnt_o != 16'hFFFF) begin
                slip_cnt_o <= slip_cnt_o + 16'd1;
            end
            if (unlock_ev && unlock_cnt_o != 16'hFFFF) begin
                unlock_cnt_o <= unlock_cnt_o + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_gearbox_block_sync.sv
// Self-checking bench for gearbox_block_sync: randomized word streams against a queue-based alignment model.
// Stats outputs are checked when BLOCK_SYNC_STATS_EN is defined.
module tb_gearbox_block_sync;

    localparam int LOCK_CNT   = 64;
    localparam int WINDOW     = 64;
    localparam int UNLOCK_BAD = 16;
    localparam int SLIP_WAIT  = 8;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [65:0] data66_i;
    logic        data66_valid_i;
    logic        slip_o;
    logic        locked_o;
`ifdef BLOCK_SYNC_STATS_EN
    logic [15:0] slip_cnt_o;
    logic [15:0] unlock_cnt_o;
`endif

    gearbox_block_sync #(
        .LOCK_CNT  (LOCK_CNT),
        .WINDOW    (WINDOW),
        .UNLOCK_BAD(UNLOCK_BAD),
        .SLIP_WAIT (SLIP_WAIT)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .data66_i      (data66_i),
        .data66_valid_i(data66_valid_i),
        .slip_o        (slip_o),
`ifdef BLOCK_SYNC_STATS_EN
        .slip_cnt_o    (slip_cnt_o),
        .unlock_cnt_o  (unlock_cnt_o),
`endif
        .locked_o      (locked_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model: words left to skip after a slip, current good run, and the bad flags of the open window.
    bit m_locked  = 1'b0;
    int m_skip    = 0;
    int m_run     = 0;
    bit m_win[$];
    int m_slips   = 0;
    int m_unlocks = 0;
    bit exp_slip  = 1'b0;
    bit exp_locked = 1'b0;

    bit pat [64];

    function automatic logic [1:0] good_hdr();
        return ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
    endfunction

    function automatic logic [1:0] bad_hdr();
        return ($urandom_range(0, 1) != 0) ? 2'b00 : 2'b11;
    endfunction

    task automatic model_step(input bit rst, input bit vld, input logic [1:0] hdr);
        bit ok;
        int nbad;
        ok = (hdr == 2'b01) || (hdr == 2'b10);
        exp_slip = 1'b0;
        if (rst) begin
            m_locked  = 1'b0;
            m_skip    = 0;
            m_run     = 0;
            m_win.delete();
            m_slips   = 0;
            m_unlocks = 0;
        end else if (vld) begin
            if (m_skip > 0) begin
                m_skip--;
            end else if (!m_locked) begin
                if (ok) begin
                    m_run++;
                    if (m_run == LOCK_CNT) begin
                        m_locked = 1'b1;
                        m_run    = 0;
                        m_win.delete();
                    end
                end else begin
                    m_run    = 0;
                    m_skip   = SLIP_WAIT;
                    exp_slip = 1'b1;
                end
            end else begin
                m_win.push_back(!ok);
                nbad = 0;
                foreach (m_win[i]) nbad += int'(m_win[i]);
                if (nbad == UNLOCK_BAD) begin
                    m_locked = 1'b0;
                    m_skip   = SLIP_WAIT;
                    m_run    = 0;
                    exp_slip = 1'b1;
                    m_unlocks++;
                    m_win.delete();
                end else if (m_win.size() == WINDOW) begin
                    m_win.delete();
                end
            end
        end
        if (exp_slip && m_slips < 65535) m_slips++;
        exp_locked = m_locked;
    endtask

    task automatic step(input bit rst, input bit vld, input logic [1:0] hdr);
        rst_i          = rst;
        data66_valid_i = vld;
        data66_i       = {hdr, $urandom(), $urandom()};
        @(posedge clk_i);
        model_step(rst, vld, hdr);
        @(negedge clk_i);
        cyc++;
    endtask

    // Spread n_bad bad flags randomly over the first n_words entries of pat.
    task automatic make_pattern(input int n_words, input int n_bad);
        bit t;
        int j;
        for (int i = 0; i < 64; i++) pat[i] = (i < n_bad);
        for (int i = n_words - 1; i > 0; i--) begin
            j      = int'($urandom_range(0, i));
            t      = pat[i];
            pat[i] = pat[j];
            pat[j] = t;
        end
    endtask

    task automatic relock();
        step(1'b1, 1'b0, 2'b00);
        for (int i = 0; i < LOCK_CNT; i++) step(1'b0, 1'b1, good_hdr());
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, bad_hdr());
        step(1'b1, 1'b0, 2'b00);
        n_checks++;
        if (slip_o !== 1'b0 || locked_o !== 1'b0)
            $display("FAIL reset slip/locked got %b/%b want 0/0", slip_o, locked_o);
        else n_pass++;
`ifdef BLOCK_SYNC_STATS_EN
        n_checks++;
        if (slip_cnt_o !== 16'd0 || unlock_cnt_o !== 16'd0)
            $display("FAIL reset_stats got %0d/%0d want 0/0", slip_cnt_o, unlock_cnt_o);
        else n_pass++;
`endif
    endtask

    task automatic test_aligned();
        for (int i = 0; i < LOCK_CNT; i++) begin
            step(1'b0, 1'b1, 2'b01);
            n_checks++;
            if (slip_o !== 1'b0 || locked_o !== (i == LOCK_CNT - 1))
                $display("FAIL aligned word=%0d slip/locked got %b/%b want 0/%b",
                         i, slip_o, locked_o, (i == LOCK_CNT - 1));
            else n_pass++;
        end
    endtask

    task automatic test_misaligned();
        int offset     = 5;
        int pulses     = 0;
        int last_slip  = -1;
        logic [1:0] h;
        step(1'b1, 1'b0, 2'b00);
        for (int c = 0; c < 8000 && locked_o !== 1'b1; c++) begin
            h = (offset == 0) ? good_hdr() : 2'($urandom_range(0, 3));
            step(1'b0, ($urandom_range(0, 3) != 0), h);
            n_checks++;
            if (slip_o !== exp_slip || locked_o !== exp_locked)
                $display("FAIL misaligned cyc=%0d slip/locked got %b/%b want %b/%b",
                         cyc, slip_o, locked_o, exp_slip, exp_locked);
            else n_pass++;
            if (slip_o === 1'b1) begin
                if (last_slip >= 0) begin
                    n_checks++;
                    if (cyc - last_slip < SLIP_WAIT + 1)
                        $display("FAIL slip_spacing got %0d cycles want >= %0d", cyc - last_slip, SLIP_WAIT + 1);
                    else n_pass++;
                end
                last_slip = cyc;
                pulses++;
                offset = (offset + 1) % 66;
            end
        end
        n_checks++;
        if (locked_o !== 1'b1 || pulses != 61)
            $display("FAIL misaligned_lock locked=%b pulses=%0d want locked=1 pulses=61", locked_o, pulses);
        else n_pass++;
`ifdef BLOCK_SYNC_STATS_EN
        n_checks++;
        if (slip_cnt_o !== 16'(pulses))
            $display("FAIL misaligned_slip_cnt got %0d want %0d", slip_cnt_o, pulses);
        else n_pass++;
`endif
    endtask

    task automatic test_window_15();
        relock();
        for (int w = 0; w < 2; w++) begin
            make_pattern(WINDOW, UNLOCK_BAD - 1);
            for (int i = 0; i < WINDOW; i++) begin
                step(1'b0, 1'b1, pat[i] ? bad_hdr() : good_hdr());
                n_checks++;
                if (slip_o !== exp_slip || locked_o !== exp_locked)
                    $display("FAIL window15 w=%0d i=%0d slip/locked got %b/%b want %b/%b",
                             w, i, slip_o, locked_o, exp_slip, exp_locked);
                else n_pass++;
            end
            n_checks++;
            if (locked_o !== 1'b1 || slip_o !== 1'b0)
                $display("FAIL window15_end w=%0d slip/locked got %b/%b want 0/1", w, slip_o, locked_o);
            else n_pass++;
        end
    endtask

    task automatic test_window_16();
        int last_bad = 0;
        relock();
        make_pattern(WINDOW, UNLOCK_BAD);
        for (int i = 0; i < WINDOW; i++) if (pat[i]) last_bad = i;
        for (int i = 0; i < WINDOW; i++) begin
            step(1'b0, 1'b1, pat[i] ? bad_hdr() : good_hdr());
            n_checks++;
            if (slip_o !== exp_slip || locked_o !== exp_locked)
                $display("FAIL window16 i=%0d slip/locked got %b/%b want %b/%b",
                         i, slip_o, locked_o, exp_slip, exp_locked);
            else n_pass++;
            if (i == last_bad) begin
                n_checks++;
                if (slip_o !== 1'b1 || locked_o !== 1'b0)
                    $display("FAIL window16_unlock slip/locked got %b/%b want 1/0", slip_o, locked_o);
                else n_pass++;
            end
        end
    endtask

    task automatic test_unlock_wins();
        relock();
        make_pattern(WINDOW - 1, UNLOCK_BAD - 1);
        pat[WINDOW - 1] = 1'b1;
        for (int i = 0; i < WINDOW; i++) begin
            step(1'b0, 1'b1, pat[i] ? bad_hdr() : good_hdr());
            n_checks++;
            if (slip_o !== exp_slip || locked_o !== exp_locked)
                $display("FAIL unlock_wins i=%0d slip/locked got %b/%b want %b/%b",
                         i, slip_o, locked_o, exp_slip, exp_locked);
            else n_pass++;
        end
        n_checks++;
        if (slip_o !== 1'b1 || locked_o !== 1'b0)
            $display("FAIL unlock_wins_end slip/locked got %b/%b want 1/0", slip_o, locked_o);
        else n_pass++;
`ifdef BLOCK_SYNC_STATS_EN
        n_checks++;
        if (unlock_cnt_o !== 16'd1 || slip_cnt_o !== 16'd1)
            $display("FAIL unlock_wins_stats unlock/slip got %0d/%0d want 1/1", unlock_cnt_o, slip_cnt_o);
        else n_pass++;
`endif
    endtask

    task automatic test_valid_gap();
        step(1'b1, 1'b0, 2'b00);
        for (int i = 0; i < 30; i++) step(1'b0, 1'b1, good_hdr());
        for (int i = 0; i < 100; i++) begin
            step(1'b0, 1'b0, ($urandom_range(0, 1) != 0) ? bad_hdr() : good_hdr());
            n_checks++;
            if (slip_o !== 1'b0 || locked_o !== 1'b0)
                $display("FAIL valid_gap idle=%0d slip/locked got %b/%b want 0/0", i, slip_o, locked_o);
            else n_pass++;
        end
        for (int i = 0; i < LOCK_CNT - 30; i++) begin
            step(1'b0, 1'b1, good_hdr());
            n_checks++;
            if (slip_o !== 1'b0 || locked_o !== (i == LOCK_CNT - 31))
                $display("FAIL valid_gap word=%0d slip/locked got %b/%b want 0/%b",
                         i, slip_o, locked_o, (i == LOCK_CNT - 31));
            else n_pass++;
        end
    endtask

    task automatic test_reset_in_wait();
        step(1'b1, 1'b0, 2'b00);
        step(1'b0, 1'b1, bad_hdr());
        n_checks++;
        if (slip_o !== 1'b1) $display("FAIL wait_first_slip got %b want 1", slip_o);
        else n_pass++;
        // Five counted words (the first alongside the pulse) leave three to go.
        for (int i = 0; i < SLIP_WAIT - 3; i++) step(1'b0, 1'b1, bad_hdr());
        n_checks++;
        if (slip_o !== 1'b0 || locked_o !== 1'b0)
            $display("FAIL wait_hold slip/locked got %b/%b want 0/0", slip_o, locked_o);
        else n_pass++;
        step(1'b1, 1'b1, bad_hdr());
        n_checks++;
        if (slip_o !== 1'b0 || locked_o !== 1'b0)
            $display("FAIL wait_reset slip/locked got %b/%b want 0/0", slip_o, locked_o);
        else n_pass++;
        step(1'b0, 1'b1, bad_hdr());
        n_checks++;
        if (slip_o !== 1'b1) $display("FAIL wait_fresh_slip got %b want 1", slip_o);
        else n_pass++;
        step(1'b0, 1'b1, bad_hdr());
        n_checks++;
        if (slip_o !== 1'b0) $display("FAIL wait_no_double_slip got %b want 0", slip_o);
        else n_pass++;
    endtask

    task automatic test_random();
        int p_bad;
        logic [1:0] h;
        step(1'b1, 1'b0, 2'b00);
        for (int s = 0; s < 12; s++) begin
            case ($urandom_range(0, 2))
                0:       p_bad = 0;
                1:       p_bad = 1;
                default: p_bad = 40;
            endcase
            for (int i = 0; i < 300; i++) begin
                h = (int'($urandom_range(0, 99)) < p_bad) ? bad_hdr() : good_hdr();
                step(($urandom_range(0, 499) == 0), ($urandom_range(0, 3) != 0), h);
                n_checks++;
                if (slip_o !== exp_slip || locked_o !== exp_locked)
                    $display("FAIL random cyc=%0d slip/locked got %b/%b want %b/%b",
                             cyc, slip_o, locked_o, exp_slip, exp_locked);
                else n_pass++;
`ifdef BLOCK_SYNC_STATS_EN
                n_checks++;
                if (slip_cnt_o !== 16'(m_slips) || unlock_cnt_o !== 16'(m_unlocks))
                    $display("FAIL random_stats cyc=%0d slip/unlock got %0d/%0d want %0d/%0d",
                             cyc, slip_cnt_o, unlock_cnt_o, m_slips, m_unlocks);
                else n_pass++;
`endif
            end
        end
    endtask

    initial begin
        rst_i          = 1'b1;
        data66_valid_i = 1'b0;
        data66_i       = '0;
        @(negedge clk_i);
        test_reset();
        test_aligned();
        test_misaligned();
        test_window_15();
        test_window_16();
        test_unlock_wins();
        test_valid_gap();
        test_reset_in_wait();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
